// File: rtl/cpu_pkg.sv
// Shared encodings for the MEM/WB stage: writeback source selects,
// the link register index and the dmem handshake FSM states.
package cpu_pkg;

    localparam logic [2:0] SUPER_SEL_ALU = 3'd0;
    localparam logic [2:0] SUPER_SEL_HI  = 3'd1;
    localparam logic [2:0] SUPER_SEL_LO  = 3'd2;
    localparam logic [2:0] SUPER_SEL_SH  = 3'd3;
    localparam logic [2:0] SUPER_SEL_PC4 = 3'd4;

    localparam logic [4:0] REG_RA = 5'd31;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and memory.
// Ports: dmem_req/we/addr/wdata (master->slave), dmem_ack/rdata (slave->master).
interface mem_wb_stage_if #(
    parameter int DW = 32
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/hilo_reg.sv
// HI/LO register pair loaded together from a 2*DW product.
// Ports: clk, rst_n (async low), we_i, d_i[2*DW-1:0], hi_o, lo_o.
module hilo_reg #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [2*DW-1:0] d_i,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o
);

    logic [DW-1:0] hi_q, lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we_i) begin
            hi_q <= d_i[2*DW-1:DW];
            lo_q <= d_i[DW-1:0];
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: redirect resolve, dmem handshake with
// wait-state stall and timeout, HI/LO ownership, writeback word select.
// Ports: clk, rst_n, EX/MEM controls and data (*M), dmem bus (interface),
// stallM, pc_redirect/pc_target, hi_q/lo_q, we_regW/rf_waW/wd_rfW, err_dmem.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           validM,
    input  logic           multu_enM,
    input  logic           jr_selM,
    input  logic           branchM,
    input  logic           dm2regM,
    input  logic           jumpM,
    input  logic           we_dm,
    input  logic           jal_selM,
    input  logic           we_regM,
    input  logic [2:0]     super_selM,
    input  logic           zeroM,
    input  logic [DW-1:0]  pc_plus_4M,
    input  logic [DW-1:0]  btaM,
    input  logic [DW-1:0]  jtaM,
    input  logic [DW-1:0]  alu_paM,
    input  logic [DW-1:0]  wd_dm,
    input  logic [DW-1:0]  shiftyM,
    input  logic [63:0]    alu_outM,
    input  logic [AW-1:0]  rf_waM,
    mem_wb_stage_if.master dmem,
    output logic           stallM,
    output logic           pc_redirect,
    output logic [DW-1:0]  pc_target,
    output logic [DW-1:0]  hi_q,
    output logic [DW-1:0]  lo_q,
    output logic           we_regW,
    output logic [AW-1:0]  rf_waW,
    output logic [DW-1:0]  wd_rfW,
    output logic           err_dmem
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          we_regW_q;
    logic [AW-1:0] rf_waW_q;
    logic [DW-1:0] wd_rfW_q;

    logic          mem_op, req, stall, retire;
    logic          redir;
    logic [DW-1:0] tgt, wb_word;

    assign mem_op = validM & (dm2regM | we_dm);

    // cnt counts stalled cycles; the IDLE miss cycle is the first one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        req     = 1'b0;
        stall   = 1'b0;
        if (state_q == IDLE) begin
            if (mem_op) begin
                req = 1'b1;
                if (!dmem.dmem_ack) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
        end else begin
            req = 1'b1;
            if (dmem.dmem_ack) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q == CW'(TIMEOUT)) begin
                // give up: retire without data, flag it
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b1;
            end else begin
                stall = 1'b1;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign retire = validM & ~stall;

    always_comb begin
        redir = 1'b0;
        tgt   = '0;
        if (retire) begin
            if (jr_selM) begin
                redir = 1'b1;
                tgt   = alu_paM;
            end else if (jumpM) begin
                redir = 1'b1;
                tgt   = jtaM;
            end else if (branchM & zeroM) begin
                redir = 1'b1;
                tgt   = btaM;
            end
        end
    end

    // load data only exists in the ack cycle; a timed-out load writes 0
    always_comb begin
        case (super_selM)
            SUPER_SEL_ALU: wb_word = alu_outM[DW-1:0];
            SUPER_SEL_HI:  wb_word = hi_q;
            SUPER_SEL_LO:  wb_word = lo_q;
            SUPER_SEL_SH:  wb_word = shiftyM;
            SUPER_SEL_PC4: wb_word = pc_plus_4M;
            default:       wb_word = '0;
        endcase
        if (jal_selM) wb_word = pc_plus_4M;
        if (dm2regM) wb_word = dmem.dmem_ack ? dmem.dmem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            we_regW_q <= 1'b0;
            rf_waW_q  <= '0;
            wd_rfW_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (retire) begin
                we_regW_q <= we_regM;
                rf_waW_q  <= jal_selM ? AW'(REG_RA) : rf_waM;
                wd_rfW_q  <= wb_word;
            end else begin
                we_regW_q <= 1'b0;
            end
        end
    end

    hilo_reg #(.DW(DW)) u_hilo (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (retire & multu_enM),
        .d_i   (alu_outM),
        .hi_o  (hi_q),
        .lo_o  (lo_q)
    );

    // combinational outputs forced low while reset is asserted
    assign dmem.dmem_req   = req & rst_n;
    assign dmem.dmem_we    = req & rst_n & we_dm;
    assign dmem.dmem_addr  = (req & rst_n) ? alu_outM[DW-1:0] : '0;
    assign dmem.dmem_wdata = (req & rst_n) ? wd_dm : '0;

    assign stallM      = stall & rst_n;
    assign pc_redirect = redir & rst_n;
    assign pc_target   = rst_n ? tgt : '0;

    assign we_regW  = we_regW_q;
    assign rf_waW   = rf_waW_q;
    assign wd_rfW   = wd_rfW_q;
    assign err_dmem = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a transaction-level model.
// Each instruction is held until it retires; ack latency is chosen per op.
module tb_mem_wb_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic validM, multu_enM, jr_selM, branchM, dm2regM, jumpM;
    logic we_dm, jal_selM, we_regM, zeroM;
    logic [2:0] super_selM;
    logic [DW-1:0] pc_plus_4M, btaM, jtaM, alu_paM, wd_dm, shiftyM;
    logic [63:0] alu_outM;
    logic [AW-1:0] rf_waM;
    logic stallM, pc_redirect, we_regW, err_dmem;
    logic [DW-1:0] pc_target, hi_q, lo_q, wd_rfW;
    logic [AW-1:0] rf_waW;

    mem_wb_stage_if #(.DW(DW)) dmem ();

    mem_wb_stage #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .validM(validM),
        .multu_enM(multu_enM), .jr_selM(jr_selM),
        .branchM(branchM), .dm2regM(dm2regM),
        .jumpM(jumpM), .we_dm(we_dm), .jal_selM(jal_selM),
        .we_regM(we_regM), .super_selM(super_selM),
        .zeroM(zeroM), .pc_plus_4M(pc_plus_4M),
        .btaM(btaM), .jtaM(jtaM), .alu_paM(alu_paM),
        .wd_dm(wd_dm), .shiftyM(shiftyM),
        .alu_outM(alu_outM), .rf_waM(rf_waM),
        .dmem(dmem), .stallM(stallM),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
        .hi_q(hi_q), .lo_q(lo_q), .we_regW(we_regW),
        .rf_waW(rf_waW), .wd_rfW(wd_rfW),
        .err_dmem(err_dmem)
    );

    typedef struct {
        logic v, mu, jr, br, ld, j, st, jal, we, z;
        logic [2:0] ss;
        logic [31:0] pc4, bta, jta, pa, wd, sh;
        logic [63:0] alu;
        logic [4:0] wa;
    } ins_t;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_hi = 0, m_lo = 0, m_wd = 0;
    logic [4:0] m_wa = 0;
    logic m_we = 0, m_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t i;
        i.v = 0; i.mu = 0; i.jr = 0; i.br = 0; i.ld = 0;
        i.j = 0; i.st = 0; i.jal = 0; i.we = 0; i.z = 0;
        i.ss = 0; i.pc4 = 0; i.bta = 0; i.jta = 0; i.pa = 0;
        i.wd = 0; i.sh = 0; i.alu = 0; i.wa = 0;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i = nop();
        int k = $urandom_range(0, 7);
        i.v = ($urandom_range(0, 9) != 0);
        i.ss = 3'($urandom_range(0, 7));
        i.z = 1'($urandom);
        i.pc4 = $urandom; i.bta = $urandom; i.jta = $urandom;
        i.pa = $urandom; i.wd = $urandom; i.sh = $urandom;
        i.alu = {$urandom, $urandom};
        i.wa = 5'($urandom);
        case (k)
            0: i.we = 1;
            1: begin i.ld = 1; i.we = 1; end
            2: i.st = 1;
            3: i.mu = 1;
            4: i.br = 1;
            5: i.j = 1;
            6: begin i.jr = 1; i.j = 1'($urandom); i.br = 1'($urandom); end
            default: begin i.j = 1; i.jal = 1; i.we = 1; end
        endcase
        return i;
    endfunction

    task automatic drive(input ins_t i);
        validM = i.v; multu_enM = i.mu; jr_selM = i.jr;
        branchM = i.br; dm2regM = i.ld; jumpM = i.j;
        we_dm = i.st; jal_selM = i.jal; we_regM = i.we;
        zeroM = i.z; super_selM = i.ss; pc_plus_4M = i.pc4;
        btaM = i.bta; jtaM = i.jta; alu_paM = i.pa;
        wd_dm = i.wd; shiftyM = i.sh; alu_outM = i.alu;
        rf_waM = i.wa;
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_wd = 0; m_wa = 0; m_we = 0; m_err = 0;
    endtask

    // Called right after a negedge; returns right after the next check.
    task automatic run(input ins_t i, input int lat, input logic [31:0] rdv);
        bit mop = i.v && (i.ld || i.st);
        bit tout = mop && (lat < 0 || lat > TMO);
        int fin = !mop ? 0 : (tout ? TMO : lat);
        bit exp_r;
        logic [31:0] exp_t, word;
        logic [31:0] src [8];
        drive(i);
        for (int c = 0; c <= fin; c++) begin
            dmem.dmem_ack = mop && (c == lat);
            dmem.dmem_rdata = (c == lat) ? rdv : $urandom;
            #1;
            chk("stall", stallM, c < fin);
            chk("req", dmem.dmem_req, mop);
            if (mop) begin
                chk("addr", dmem.dmem_addr, i.alu[31:0]);
                chk("dwe", dmem.dmem_we, i.st);
                if (i.st) chk("wdata", dmem.dmem_wdata, i.wd);
            end
            if (c > 0) chk("bubble", we_regW, 0);
            if (c == fin) begin
                exp_r = i.v && (i.jr || i.j || (i.br && i.z));
                exp_t = !exp_r ? 0 : i.jr ? i.pa : i.j ? i.jta : i.bta;
                chk("redir", pc_redirect, exp_r);
                chk("target", pc_target, exp_t);
            end else begin
                chk("redir_hold", pc_redirect, 0);
            end
            @(negedge clk);
        end
        dmem.dmem_ack = 0;
        if (i.v) begin
            src[0] = i.alu[31:0]; src[1] = m_hi; src[2] = m_lo;
            src[3] = i.sh; src[4] = i.pc4;
            src[5] = 0; src[6] = 0; src[7] = 0;
            word = src[i.ss];
            if (i.jal) word = i.pc4;
            if (i.ld) word = tout ? 32'h0 : rdv;
            m_we = i.we;
            m_wa = i.jal ? 5'd31 : i.wa;
            m_wd = word;
            if (i.mu) begin
                m_hi = i.alu[63:32];
                m_lo = i.alu[31:0];
            end
            if (tout) m_err = 1;
        end else begin
            m_we = 0;
        end
        #1;
        chk("we_regW", we_regW, m_we);
        chk("rf_waW", rf_waW, m_wa);
        chk("wd_rfW", wd_rfW, m_wd);
        chk("hi", hi_q, m_hi);
        chk("lo", lo_q, m_lo);
        chk("err", err_dmem, m_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, dmem.dmem_req, 0);
        chk({tag, "_stall"}, stallM, 0);
        chk({tag, "_redir"}, pc_redirect, 0);
        chk({tag, "_tgt"}, pc_target, 0);
        chk({tag, "_we"}, we_regW, 0);
        chk({tag, "_wa"}, rf_waW, 0);
        chk({tag, "_wd"}, wd_rfW, 0);
        chk({tag, "_hilo"}, {hi_q, lo_q}, 0);
        chk({tag, "_err"}, err_dmem, 0);
    endtask

    initial begin
        ins_t i;
        dmem.dmem_ack = 0;
        dmem.dmem_rdata = 0;
        i = nop(); i.v = 1; i.ld = 1; i.we = 1; i.jr = 1; i.pa = 32'h55;
        drive(i);
        #2;
        chk_all_zero("rst");
        drive(nop());
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // lw, ack same cycle
        i = nop(); i.v = 1; i.ld = 1; i.we = 1; i.wa = 8;
        i.alu = 64'h100;
        run(i, 0, 32'hDEADBEEF);
        chk("lw_wd", wd_rfW, 32'hDEADBEEF);
        chk("lw_wa", rf_waW, 8);

        // sw, ack after 3 cycles
        i = nop(); i.v = 1; i.st = 1; i.alu = 64'h200; i.wd = 32'hCAFE;
        run(i, 3, 0);

        // multu then mfhi / mflo
        i = nop(); i.v = 1; i.mu = 1; i.alu = 64'h0000_0001_FFFF_FFFE;
        run(i, 0, 0);
        i = nop(); i.v = 1; i.we = 1; i.wa = 2; i.ss = 1;
        run(i, 0, 0);
        chk("mfhi", wd_rfW, 32'h1);
        i.ss = 2;
        run(i, 0, 0);
        chk("mflo", wd_rfW, 32'hFFFF_FFFE);

        // branch taken / not taken, jr over jump
        i = nop(); i.v = 1; i.br = 1; i.z = 1; i.bta = 32'h40;
        run(i, 0, 0);
        i.z = 0;
        run(i, 0, 0);
        i = nop(); i.v = 1; i.jr = 1; i.j = 1; i.pa = 32'h88;
        i.jta = 32'h99;
        run(i, 0, 0);

        // jal
        i = nop(); i.v = 1; i.j = 1; i.jal = 1; i.we = 1;
        i.pc4 = 32'h104; i.wa = 3; i.jta = 32'h500;
        run(i, 0, 0);
        chk("jal_wa", rf_waW, 31);
        chk("jal_wd", wd_rfW, 32'h104);

        // load never acked -> timeout
        i = nop(); i.v = 1; i.ld = 1; i.we = 1; i.wa = 9;
        run(i, -1, 0);
        chk("tmo_err", err_dmem, 1);

        for (int n = 0; n < 150; n++) begin
            int lat = $urandom_range(0, 5);
            if ($urandom_range(0, 24) == 0) lat = -1;
            run(rnd_ins(), lat, $urandom);
        end

        // reset in the middle of a wait
        i = nop(); i.v = 1; i.ld = 1; i.we = 1; i.alu = 64'h44;
        drive(i);
        dmem.dmem_ack = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_stall", stallM, 1);
        rst_n = 0;
        #1;
        chk_all_zero("mid_rst");
        model_reset();
        drive(nop());
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            run(rnd_ins(), $urandom_range(0, 4), $urandom);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
